// File: rtl/wb_rr_arbiter.sv
// Four-master Wishbone round-robin arbiter with slave-ack timeout.
// Ports:
//   wb_clk_i / wb_rst_i               clock, async active-low reset
//   wbm_*_i                           packed per-master requests (master n at slice n)
//   wbm_dat_o / wbm_ack_o / wbm_err_o read data broadcast, per-master ack and timeout error
//   wbs_*_o / wbs_dat_i / wbs_ack_i   shared slave bus
//   grant_o                           registered one-hot grant, zero when idle
module wb_rr_arbiter #(
    parameter int unsigned BUS_DATA_WIDTH = 32,
    parameter int unsigned BUS_ADDR_WIDTH = 8,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    localparam int unsigned BYTE_EN_WIDTH = BUS_DATA_WIDTH / 8
) (
    input  logic                          wb_clk_i,
    input  logic                          wb_rst_i,
    input  logic [3:0]                    wbm_cyc_i,
    input  logic [3:0]                    wbm_stb_i,
    input  logic [3:0]                    wbm_we_i,
    input  logic [4*BYTE_EN_WIDTH-1:0]    wbm_sel_i,
    input  logic [4*BUS_ADDR_WIDTH-1:0]   wbm_adr_i,
    input  logic [4*BUS_DATA_WIDTH-1:0]   wbm_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]     wbm_dat_o,
    output logic [3:0]                    wbm_ack_o,
    output logic [3:0]                    wbm_err_o,
    output logic                          wbs_cyc_o,
    output logic                          wbs_stb_o,
    output logic                          wbs_we_o,
    output logic [BYTE_EN_WIDTH-1:0]      wbs_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]     wbs_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]     wbs_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]     wbs_dat_i,
    input  logic                          wbs_ack_i,
    output logic [3:0]                    grant_o
);

    localparam int unsigned CNT_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             grant_q, grant_d;
    logic [1:0]             last_q, last_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [3:0]             err_q, err_d;

    logic [1:0]             winner;
    logic [1:0]             gidx;
    logic                   granted;
    logic                   abort;

    assign grant_o   = grant_q;
    assign wbm_err_o = err_q;
    assign granted   = |grant_q;
    // Slave controls are dropped during the cycle the timeout error is presented.
    assign abort     = |err_q;

    // Round-robin pick: lowest offset from last_q+1 wins (offset 4 == last_q itself).
    always_comb begin
        winner = last_q;
        for (int k = 4; k >= 1; k--) begin
            if (wbm_cyc_i[2'(last_q + 2'(k))]) begin
                winner = 2'(last_q + 2'(k));
            end
        end
    end

    // Binary index of the current one-hot grant.
    always_comb begin
        gidx = '0;
        for (int k = 0; k < 4; k++) begin
            if (grant_q[k]) begin
                gidx = 2'(k);
            end
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= 2'd3;
            cnt_q   <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: arbitration, tenure release and timeout counting.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        err_d   = '0;
        case (state_q)
            IDLE: begin
                if (|wbm_cyc_i) begin
                    grant_d = 4'b0001 << winner;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (!wbm_cyc_i[gidx]) begin
                    grant_d = '0;
                    last_d  = gidx;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (!wbs_stb_o || wbs_ack_i) begin
                    // Ack has priority over a simultaneous timeout.
                    cnt_d = '0;
                end else if (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1)) begin
                    err_d = grant_q;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: granted master's fields onto the slave bus, ack routed back.
    always_comb begin
        wbs_cyc_o = 1'b0;
        wbs_stb_o = 1'b0;
        wbs_we_o  = 1'b0;
        wbs_sel_o = '0;
        wbs_adr_o = '0;
        wbs_dat_o = '0;
        if (granted) begin
            wbs_cyc_o = wbm_cyc_i[gidx] & ~abort;
            wbs_stb_o = wbm_stb_i[gidx] & ~abort;
            wbs_we_o  = wbm_we_i[gidx];
            wbs_sel_o = wbm_sel_i[32'(gidx) * BYTE_EN_WIDTH +: BYTE_EN_WIDTH];
            wbs_adr_o = wbm_adr_i[32'(gidx) * BUS_ADDR_WIDTH +: BUS_ADDR_WIDTH];
            wbs_dat_o = wbm_dat_i[32'(gidx) * BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
        end
        wbm_ack_o = grant_q & {4{wbs_ack_i & wbs_stb_o}};
        wbm_dat_o = wbs_dat_i;
    end

endmodule
